// File: rtl/fpu_wb_sched.sv
// FP issue scoreboard and register-file writeback arbiter.
// Issue is held while a source or destination register has a result in flight.
// The FMA pipe and the DIV/SQRT unit share one write port, and the FMA pipe has priority.
// A starvation guard blocks FMA issue when a DIV result has waited too long,
// so that the FMA pipe drains and frees a write slot.
module fpu_wb_sched #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     iss_valid_i,
  output logic                     iss_ready_o,
  input  logic                     iss_unit_i,
  input  logic [ADDR_WIDTH-1:0]    iss_rd_i,
  input  logic [ADDR_WIDTH-1:0]    iss_rs1_i,
  input  logic [ADDR_WIDTH-1:0]    iss_rs2_i,
  input  logic [ADDR_WIDTH-1:0]    iss_rs3_i,
  input  logic                     iss_use_rs3_i,
  input  logic                     div_ready_i,
  input  logic                     fma_wb_valid_i,
  input  logic [ADDR_WIDTH-1:0]    fma_wb_rd_i,
  input  logic [DATA_WIDTH-1:0]    fma_wb_data_i,
  input  logic                     div_wb_valid_i,
  output logic                     div_wb_ready_o,
  input  logic [ADDR_WIDTH-1:0]    div_wb_rd_i,
  input  logic [DATA_WIDTH-1:0]    div_wb_data_i,
  output logic                     rd_wren_o,
  output logic [ADDR_WIDTH-1:0]    rd_addr_o,
  output logic [DATA_WIDTH-1:0]    rd_data_o,
  output logic [2**ADDR_WIDTH-1:0] busy_o,
  output logic                     wb_err_o
);

  localparam int NREG     = 2**ADDR_WIDTH;
  localparam int SW       = $clog2(STARVE_LIMIT + 1);
  localparam int WD_LIMIT = STARVE_LIMIT + 64;
  localparam int WW       = $clog2(WD_LIMIT + 2);
  localparam logic [SW-1:0] SLIM   = STARVE_LIMIT[SW-1:0];
  localparam logic [WW-1:0] WD_LIM = WD_LIMIT[WW-1:0];
  localparam logic [WW-1:0] WD_SAT = WD_LIM + 1'b1;
  localparam logic [ADDR_WIDTH-1:0] F0 = '0;

  logic [NREG-1:0]       r_busy;
  logic [NREG-1:0]       w_busy_nxt;
  logic [SW-1:0]         r_starve;
  logic [WW-1:0]         r_refuse;
  logic                  r_wren;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_err;

  logic                  w_stall;
  logic                  w_fire;
  logic                  w_div_hs;
  logic                  w_sel_valid;
  logic [ADDR_WIDTH-1:0] w_sel_rd;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_err_acc;
  logic                  w_err_wd;
  logic                  w_starved;

  assign w_starved = (r_starve == SLIM);

  // Issue hazard check: RAW on sources, WAW on the destination, unit availability.
  always_comb begin
    w_stall = 1'b0;
    if (r_busy[iss_rs1_i] || r_busy[iss_rs2_i])         w_stall = 1'b1;
    if (iss_use_rs3_i && r_busy[iss_rs3_i])             w_stall = 1'b1;
    if ((iss_rd_i != F0) && r_busy[iss_rd_i])           w_stall = 1'b1;
    if (iss_unit_i && !div_ready_i)                     w_stall = 1'b1;
    if (!iss_unit_i && w_starved)                       w_stall = 1'b1;
  end

  assign iss_ready_o    = !w_stall;
  assign w_fire         = iss_valid_i && iss_ready_o;
  assign div_wb_ready_o = !fma_wb_valid_i;
  assign w_div_hs       = div_wb_valid_i && div_wb_ready_o;

  // FMA cannot stall, so it always wins the write port; DIV fills the gaps.
  always_comb begin
    w_sel_valid = fma_wb_valid_i || div_wb_valid_i;
    w_sel_rd    = fma_wb_valid_i ? fma_wb_rd_i   : div_wb_rd_i;
    w_sel_data  = fma_wb_valid_i ? fma_wb_data_i : div_wb_data_i;
  end

  // An accepted result is always the selected one, so one check covers both sources.
  assign w_err_acc = w_sel_valid && (w_sel_rd != F0) && !r_busy[w_sel_rd];
  assign w_err_wd  = fma_wb_valid_i && div_wb_valid_i && (r_refuse > WD_LIM);

  // Next scoreboard: clear on the write port, then set on issue so that set wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_wren && (r_addr != F0)) w_busy_nxt[r_addr]   = 1'b0;
    if (w_fire && (iss_rd_i != F0)) w_busy_nxt[iss_rd_i] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  // Starvation and watchdog counters track how long the pending DIV result is refused.
  always_ff @(posedge clk_i) begin
    if (rst_i || !div_wb_valid_i || w_div_hs) begin
      r_starve <= '0;
      r_refuse <= '0;
    end else begin
      if (r_starve != SLIM)   r_starve <= r_starve + 1'b1;
      if (r_refuse != WD_SAT) r_refuse <= r_refuse + 1'b1;
    end
  end

  // Registered write port; address and data hold when no result is selected.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wren <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_wren <= w_sel_valid;
      if (w_sel_valid) begin
        r_addr <= w_sel_rd;
        r_data <= w_sel_data;
      end
    end
  end

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i)                       r_err <= 1'b0;
    else if (w_err_acc || w_err_wd)  r_err <= 1'b1;
  end

  assign rd_wren_o = r_wren;
  assign rd_addr_o = r_addr;
  assign rd_data_o = r_data;
  assign busy_o    = r_busy;
  assign wb_err_o  = r_err;

endmodule

// File: tb/tb_fpu_wb_sched.sv
// Directed bench for fpu_wb_sched with a writeback scoreboard.
module tb_fpu_wb_sched;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        iss_valid_i, iss_ready_o, iss_unit_i, iss_use_rs3_i;
  logic [4:0]  iss_rd_i, iss_rs1_i, iss_rs2_i, iss_rs3_i;
  logic        div_ready_i;
  logic        fma_wb_valid_i;
  logic [4:0]  fma_wb_rd_i;
  logic [31:0] fma_wb_data_i;
  logic        div_wb_valid_i, div_wb_ready_o;
  logic [4:0]  div_wb_rd_i;
  logic [31:0] div_wb_data_i;
  logic        rd_wren_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic [31:0] busy_o;
  logic        wb_err_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [36:0] sb_q[$];

  fpu_wb_sched #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .STARVE_LIMIT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .iss_valid_i(iss_valid_i), .iss_ready_o(iss_ready_o), .iss_unit_i(iss_unit_i),
    .iss_rd_i(iss_rd_i), .iss_rs1_i(iss_rs1_i), .iss_rs2_i(iss_rs2_i), .iss_rs3_i(iss_rs3_i),
    .iss_use_rs3_i(iss_use_rs3_i), .div_ready_i(div_ready_i),
    .fma_wb_valid_i(fma_wb_valid_i), .fma_wb_rd_i(fma_wb_rd_i), .fma_wb_data_i(fma_wb_data_i),
    .div_wb_valid_i(div_wb_valid_i), .div_wb_ready_o(div_wb_ready_o),
    .div_wb_rd_i(div_wb_rd_i), .div_wb_data_i(div_wb_data_i),
    .rd_wren_o(rd_wren_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
    .busy_o(busy_o), .wb_err_o(wb_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_iss(input logic v, input logic unit, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rs3, input logic use3);
    iss_valid_i = v; iss_unit_i = unit; iss_rd_i = rd;
    iss_rs1_i = rs1; iss_rs2_i = rs2; iss_rs3_i = rs3; iss_use_rs3_i = use3;
  endtask

  task automatic fma_wb(input logic [4:0] rd, input logic [31:0] data);
    fma_wb_valid_i = 1'b1; fma_wb_rd_i = rd; fma_wb_data_i = data;
    tick();
    fma_wb_valid_i = 1'b0;
  endtask

  // Reference arbitration: FMA first, DIV otherwise; each accepted result is written next cycle.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      if (fma_wb_valid_i)      sb_q.push_back({fma_wb_rd_i, fma_wb_data_i});
      else if (div_wb_valid_i) sb_q.push_back({div_wb_rd_i, div_wb_data_i});
    end
  end

  // Compare every register-file write against the oldest expected result.
  always @(negedge clk_i) begin
    if (rd_wren_o) begin
      if (sb_q.size() == 0) chk("sb_unexpected_write", {27'd0, rd_addr_o, rd_data_o}, 64'h1_0000_0000_0000);
      else chk("sb_write", {27'd0, rd_addr_o, rd_data_o}, {27'd0, sb_q.pop_front()});
    end
  end

  initial begin
    rst_i = 1'b1;
    set_iss(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    div_ready_i = 1'b1;
    fma_wb_valid_i = 1'b0; fma_wb_rd_i = '0; fma_wb_data_i = '0;
    div_wb_valid_i = 1'b0; div_wb_rd_i = '0; div_wb_data_i = '0;

    // Reset state
    tick(); tick();
    chk("rst_busy", busy_o, 0);
    chk("rst_wren", rd_wren_o, 0);
    chk("rst_addr", rd_addr_o, 0);
    chk("rst_data", rd_data_o, 0);
    chk("rst_err", wb_err_o, 0);
    rst_i = 1'b0;

    // 1: basic issue and writeback latency
    set_iss(1'b1, 1'b0, 5'd3, 5'd1, 5'd2, 5'd0, 1'b0);
    #1 chk("t1_ready", iss_ready_o, 1);
    tick();
    iss_valid_i = 1'b0;
    chk("t1_busy_set", busy_o, 32'h8);
    fma_wb(5'd3, 32'h3F80_0000);
    chk("t1_wren", rd_wren_o, 1);
    chk("t1_addr", rd_addr_o, 3);
    chk("t1_data", rd_data_o, 32'h3F80_0000);
    chk("t1_busy_hold", busy_o, 32'h8);
    tick();
    chk("t1_busy_clr", busy_o, 0);
    chk("t1_wren_off", rd_wren_o, 0);

    // 2: RAW on rs2, then rs3 with and without use flag
    set_iss(1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    set_iss(1'b1, 1'b0, 5'd6, 5'd0, 5'd5, 5'd0, 1'b0);
    #1 chk("t2_raw_stall", iss_ready_o, 0);
    fma_wb_valid_i = 1'b1; fma_wb_rd_i = 5'd5; fma_wb_data_i = 32'h4000_0000;
    #1 chk("t2_stall_t", iss_ready_o, 0);
    tick();
    fma_wb_valid_i = 1'b0;
    chk("t2_wren5", rd_addr_o, 5);
    #1 chk("t2_stall_t1", iss_ready_o, 0);
    tick();
    #1 chk("t2_fire_t2", iss_ready_o, 1);
    tick();
    iss_valid_i = 1'b0;
    chk("t2_busy6", busy_o, 32'h40);
    set_iss(1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    set_iss(1'b1, 1'b0, 5'd8, 5'd0, 5'd0, 5'd5, 1'b1);
    #1 chk("t2_rs3_stall", iss_ready_o, 0);
    iss_use_rs3_i = 1'b0;
    #1 chk("t2_rs3_unused", iss_ready_o, 1);
    tick();
    iss_valid_i = 1'b0;
    chk("t2_busy568", busy_o, 32'h160);
    fma_wb(5'd5, 32'h1111_0005);
    fma_wb(5'd6, 32'h1111_0006);
    fma_wb(5'd8, 32'h1111_0008);
    tick();
    chk("t2_drain", busy_o, 0);

    // 3: WAW and rd=0
    set_iss(1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    #1 chk("t3_waw_stall", iss_ready_o, 0);
    iss_rd_i = 5'd0;
    #1 chk("t3_rd0_first", iss_ready_o, 1);
    tick();
    #1 chk("t3_rd0_second", iss_ready_o, 1);
    tick();
    iss_valid_i = 1'b0;
    chk("t3_busy_only7", busy_o, 32'h80);
    fma_wb(5'd7, 32'h7777_7777);
    tick();
    chk("t3_drain", busy_o, 0);

    // 4: FMA/DIV collision
    set_iss(1'b1, 1'b0, 5'd1, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    set_iss(1'b1, 1'b1, 5'd2, 5'd0, 5'd0, 5'd0, 1'b0);
    div_ready_i = 1'b0;
    #1 chk("t4_div_busy_stall", iss_ready_o, 0);
    div_ready_i = 1'b1;
    #1 chk("t4_div_issue", iss_ready_o, 1);
    tick();
    iss_valid_i = 1'b0;
    chk("t4_busy12", busy_o, 32'h6);
    fma_wb_valid_i = 1'b1; fma_wb_rd_i = 5'd1; fma_wb_data_i = 32'hAAAA_0001;
    div_wb_valid_i = 1'b1; div_wb_rd_i = 5'd2; div_wb_data_i = 32'hBBBB_0002;
    #1 chk("t4_div_refused", div_wb_ready_o, 0);
    tick();
    fma_wb_valid_i = 1'b0;
    chk("t4_w1_addr", rd_addr_o, 1);
    chk("t4_w1_data", rd_data_o, 32'hAAAA_0001);
    #1 chk("t4_div_taken", div_wb_ready_o, 1);
    tick();
    div_wb_valid_i = 1'b0;
    chk("t4_w2_wren", rd_wren_o, 1);
    chk("t4_w2_addr", rd_addr_o, 2);
    chk("t4_w2_data", rd_data_o, 32'hBBBB_0002);
    tick();
    chk("t4_drain", busy_o, 0);

    // 5: starvation guard
    set_iss(1'b1, 1'b1, 5'd10, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    set_iss(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    div_wb_valid_i = 1'b1; div_wb_rd_i = 5'd10; div_wb_data_i = 32'hD1D1_000A;
    for (int i = 0; i < 10; i++) begin
      fma_wb_valid_i = 1'b1; fma_wb_rd_i = 5'd0; fma_wb_data_i = 32'hF000_0000 + i;
      #1;
      if (i == 7) chk("t5_fma_ok_c7", iss_ready_o, 1);
      if (i == 8) begin
        chk("t5_fma_blocked_c8", iss_ready_o, 0);
        iss_unit_i = 1'b1;
        #1 chk("t5_div_issuable", iss_ready_o, 1);
        iss_unit_i = 1'b0;
      end
      tick();
    end
    fma_wb_valid_i = 1'b0;
    #1 chk("t5_gap_div_ready", div_wb_ready_o, 1);
    chk("t5_gap_still_blocked", iss_ready_o, 0);
    tick();
    div_wb_valid_i = 1'b0;
    chk("t5_div_addr", rd_addr_o, 10);
    chk("t5_div_data", rd_data_o, 32'hD1D1_000A);
    #1 chk("t5_counter_cleared", iss_ready_o, 1);
    tick();
    chk("t5_drain", busy_o, 0);
    chk("t5_no_err", wb_err_o, 0);

    // 6: error on idle register, sticky, then reset with busy bits set
    fma_wb(5'd9, 32'h9999_9999);
    chk("t6_err_set", wb_err_o, 1);
    tick();
    chk("t6_err_sticky", wb_err_o, 1);
    set_iss(1'b1, 1'b0, 5'd4, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    iss_valid_i = 1'b0;
    chk("t6_busy4", busy_o, 32'h10);
    rst_i = 1'b1;
    tick();
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_wren", rd_wren_o, 0);
    chk("t6_rst_err", wb_err_o, 0);
    rst_i = 1'b0;
    tick();
    chk("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    n_bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule
